// File: rtl/cpu_bus_master.sv
// Bus initiator for the simple CPU peripheral bus: commands are queued in a
// small FIFO, issued one at a time as single-cycle strobes, and answered in order.
module cpu_bus_master #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_we,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic          wr,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          rd,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  logic          we_mem   [FIFO_DEPTH];
  logic [AW-1:0] addr_mem [FIFO_DEPTH];
  logic [DW-1:0] data_mem [FIFO_DEPTH];

  logic [PW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic          full, empty, push, pop;
  logic          head_we;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  state_e        state_q;
  logic          cur_we_q;
  logic [CW-1:0] cnt_q;
  logic          wr_q, rd_q, rsp_valid_q, rsp_we_q;
  logic [AW-1:0] waddr_q, raddr_q;
  logic [DW-1:0] wdata_q, rsp_rdata_q;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign push  = cmd_valid & ~full;
  assign pop   = (state_q == IDLE) & ~empty;

  assign head_we   = we_mem[rptr_q[PW-1:0]];
  assign head_addr = addr_mem[rptr_q[PW-1:0]];
  assign head_data = data_mem[rptr_q[PW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{PW{1'b0}}, push};
    rptr_d = rptr_q + {{PW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      we_mem[wptr_q[PW-1:0]]   <= cmd_we;
      addr_mem[wptr_q[PW-1:0]] <= cmd_addr;
      data_mem[wptr_q[PW-1:0]] <= cmd_wdata;
    end
  end

  // Strobes are registered, so they are loaded on the IDLE->ISSUE transition
  // and are high exactly during the ISSUE cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cur_we_q    <= 1'b0;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            cur_we_q <= head_we;
            wr_q     <= head_we;
            rd_q     <= ~head_we;
            if (head_we) begin
              waddr_q <= head_addr;
              wdata_q <= head_data;
            end else begin
              raddr_q <= head_addr;
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          wr_q <= 1'b0;
          rd_q <= 1'b0;
          if (cur_we_q) begin
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= RESP;
          end else begin
            cnt_q   <= CW'(RD_LATENCY);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            rsp_rdata_q <= rdata;
            rsp_we_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = ~full;
  assign busy      = (state_q != IDLE) | ~empty;
  assign wr        = wr_q;
  assign rd        = rd_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign raddr     = raddr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Randomized self-checking bench for cpu_bus_master: lane 0 uses RD_LATENCY=1,
// lane 1 uses RD_LATENCY=3, each with its own peripheral and reference model.
module tb_cpu_bus_master;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_we    [2];
  logic [31:0] cmd_addr  [2];
  logic [31:0] cmd_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic        rsp_we    [2];
  logic [31:0] rsp_rdata [2];
  logic        busy      [2];
  logic        wr        [2];
  logic [31:0] waddr     [2];
  logic [31:0] wdata     [2];
  logic        rd        [2];
  logic [31:0] raddr     [2];
  logic [31:0] rdata     [2];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int L = (g == 0) ? 1 : 3;

    cpu_bus_master #(.AW(32), .DW(32), .RD_LATENCY(L), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_we(cmd_we[g]),
      .cmd_addr(cmd_addr[g]), .cmd_wdata(cmd_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_we(rsp_we[g]),
      .rsp_rdata(rsp_rdata[g]), .busy(busy[g]),
      .wr(wr[g]), .waddr(waddr[g]), .wdata(wdata[g]),
      .rd(rd[g]), .raddr(raddr[g]), .rdata(rdata[g])
    );

    // Peripheral: version register 0x01 at address 0 (read-only), RAM elsewhere.
    // Read data is valid only L cycles after rd; otherwise it shows a junk pattern.
    logic [31:0] smem [16];
    logic        pv   [L];
    logic [31:0] pd   [L];
    initial begin
      for (int i = 0; i < 16; i++) smem[i] = 32'h0;
      smem[0] = 32'h1;
      for (int i = 0; i < L; i++) begin pv[i] = 1'b0; pd[i] = 32'h0; end
    end
    always @(posedge clk) begin
      if (wr[g] && waddr[g][5:2] != 4'd0) smem[waddr[g][5:2]] <= wdata[g];
      pv[0] <= rd[g];
      pd[0] <= smem[raddr[g][5:2]];
      for (int i = 1; i < L; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
    end
    assign rdata[g] = pv[L-1] ? pd[L-1] : 32'hBAD0BAD0;

    // Reference model: expected strobes in acceptance order, and responses
    // evaluated against a memory image updated in response order.
    cmd_t        strobe_q [$];
    cmd_t        rsp_q    [$];
    cmd_t        c;
    logic [31:0] mdl_mem  [16];
    int          n_wr = 0, n_rd = 0, n_rsp = 0, n_acc = 0;
    int          strobe_cyc = 0;
    logic        strobe_we = 1'b0;
    logic        vld_prev = 1'b0, hold_prev = 1'b0, we_prev = 1'b0;
    logic [31:0] rdata_prev = 32'h0, last_rdata = 32'h0;
    initial begin
      for (int i = 0; i < 16; i++) mdl_mem[i] = 32'h0;
      mdl_mem[0] = 32'h1;
    end

    always @(negedge clk) begin
      if (!rstn) begin
        strobe_q.delete();
        rsp_q.delete();
        vld_prev  = 1'b0;
        hold_prev = 1'b0;
      end else begin
        if (cmd_valid[g] && cmd_ready[g]) begin
          c = '{we: cmd_we[g], addr: cmd_addr[g], data: cmd_wdata[g]};
          strobe_q.push_back(c);
          rsp_q.push_back(c);
          n_acc++;
        end
        if (wr[g] || rd[g]) begin
          chk("wr_rd_exclusive", {wr[g], rd[g]} == 2'b11, 1'b0);
          if (strobe_q.size() == 0) chk("spurious_strobe", 1'b1, 1'b0);
          else begin
            c = strobe_q.pop_front();
            chk("strobe_type", wr[g], c.we);
            chk("strobe_addr", wr[g] ? waddr[g] : raddr[g], c.addr);
            if (c.we) chk("strobe_wdata", wdata[g], c.data);
          end
          strobe_cyc = cyc;
          strobe_we  = wr[g];
          if (wr[g]) n_wr++; else n_rd++;
        end
        if (rsp_valid[g] && !vld_prev)
          chk("rsp_latency", cyc - strobe_cyc, strobe_we ? 1 : L + 1);
        if (hold_prev) begin
          chk("rsp_hold_valid", rsp_valid[g], 1'b1);
          chk("rsp_hold_we", rsp_we[g], we_prev);
          chk("rsp_hold_rdata", rsp_rdata[g], rdata_prev);
        end
        if (rsp_valid[g] && rsp_ready[g]) begin
          if (rsp_q.size() == 0) chk("spurious_rsp", 1'b1, 1'b0);
          else begin
            c = rsp_q.pop_front();
            chk("rsp_we", rsp_we[g], c.we);
            if (c.we) begin
              chk("rsp_wr_rdata", rsp_rdata[g], 32'h0);
              if (c.addr[5:2] != 4'd0) mdl_mem[c.addr[5:2]] = c.data;
            end else begin
              chk("rsp_rd_rdata", rsp_rdata[g], mdl_mem[c.addr[5:2]]);
            end
          end
          last_rdata = rsp_rdata[g];
          n_rsp++;
        end
        hold_prev  = rsp_valid[g] && !rsp_ready[g];
        vld_prev   = rsp_valid[g];
        we_prev    = rsp_we[g];
        rdata_prev = rsp_rdata[g];
      end
    end
  end

  task automatic try_send(input int l, input logic we, input logic [31:0] a, input logic [31:0] d,
                          input int budget, output bit ok);
    ok = 1'b0;
    cmd_valid[l] = 1'b1; cmd_we[l] = we; cmd_addr[l] = a; cmd_wdata[l] = d;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); ok = cmd_ready[l];
      @(posedge clk); #1;
    end
    cmd_valid[l] = 1'b0;
  endtask

  task automatic send(input int l, input logic we, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    try_send(l, we, a, d, 100, ok);
    if (!ok) chk("cmd_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_idle(input int l);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); done = !busy[l];
    end
    if (!done) chk("idle_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  s0, r0, acc, sent;
    bit  ok, hs;
    rstn = 1'b0;
    for (int l = 0; l < 2; l++) begin
      cmd_valid[l] = 1'b0; cmd_we[l] = 1'b0; cmd_addr[l] = 32'h0; cmd_wdata[l] = 32'h0;
      rsp_ready[l] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr", wr[0], 1'b0);
    chk("rst_rd", rd[0], 1'b0);
    chk("rst_rsp_valid", rsp_valid[0], 1'b0);
    chk("rst_rsp_we", rsp_we[0], 1'b0);
    chk("rst_addr_data", {waddr[0], wdata[0], raddr[0], rsp_rdata[0]} == 128'h0, 1'b1);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_lane1_outs", {wr[1], rd[1], rsp_valid[1], busy[1]}, 4'b0000);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", cmd_ready[0], 1'b1);

    // Single write, then version read, then write/read-back issued back-to-back.
    s0 = lane[0].n_wr;
    send(0, 1'b1, 32'h4, 32'h000000A5);
    wait_idle(0);
    chk("wr_one_strobe", lane[0].n_wr - s0, 1);
    chk("wr_one_rsp", lane[0].n_rsp, 1);
    chk("wr_busy_low", busy[0], 1'b0);
    send(0, 1'b0, 32'h0, 32'h0);
    wait_idle(0);
    chk("rd_version", lane[0].last_rdata, 32'h00000001);
    send(0, 1'b1, 32'h4, 32'h5A5A5A5A);
    send(0, 1'b0, 32'h4, 32'h0);
    wait_idle(0);
    chk("rd_back", lane[0].last_rdata, 32'h5A5A5A5A);
    chk("b2b_rsp_count", lane[0].n_rsp, 4);

    // Back-pressure: 5 commands fit (4 queued + 1 in the FSM), 6th is refused.
    rsp_ready[0] = 1'b0;
    s0 = lane[0].n_wr + lane[0].n_rd;
    r0 = lane[0].n_rsp;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      try_send(0, (k % 2) == 0, 32'h8, 32'h1000 + k, 6, ok);
      if (ok) acc++;
    end
    chk("bp_accepted", acc, 5);
    chk("bp_cmd_ready_low", cmd_ready[0], 1'b0);
    chk("bp_single_strobe", lane[0].n_wr + lane[0].n_rd - s0, 1);
    chk("bp_rsp_pending", rsp_valid[0], 1'b1);
    rsp_ready[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 6 && !ok; i++) begin @(negedge clk); ok = cmd_ready[0]; end
    chk("bp_cmd_ready_return", ok, 1'b1);
    wait_idle(0);
    chk("bp_rsp_count", lane[0].n_rsp - r0, 5);

    // Randomized traffic with random response back-pressure.
    r0 = lane[0].n_rsp;
    sent = 0;
    for (int cy = 0; cy < 2000 && sent < 60; cy++) begin
      @(negedge clk); hs = cmd_valid[0] && cmd_ready[0];
      @(posedge clk); #1;
      if (hs) begin sent++; cmd_valid[0] = 1'b0; end
      rsp_ready[0] = ($urandom_range(0, 3) != 0);
      if (!cmd_valid[0] && sent < 60 && $urandom_range(0, 2) != 0) begin
        cmd_we[0]    = $urandom_range(0, 1);
        cmd_addr[0]  = cmd_we[0] ? 32'(4 * $urandom_range(1, 3)) : 32'(4 * $urandom_range(0, 3));
        cmd_wdata[0] = $urandom;
        cmd_valid[0] = 1'b1;
      end
    end
    cmd_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    chk("rand_sent", sent, 60);
    wait_idle(0);
    chk("rand_rsp_count", lane[0].n_rsp - r0, 60);

    // Reset while a read sits in WAIT with two writes queued behind it.
    s0 = lane[0].n_wr + lane[0].n_rd;
    r0 = lane[0].n_rsp;
    send(0, 1'b0, 32'h4, 32'h0);
    send(0, 1'b1, 32'h8, 32'h77);
    send(0, 1'b1, 32'hC, 32'h88);
    chk("abort_rd_issued", lane[0].n_rd + lane[0].n_wr - s0, 1);
    chk("abort_no_rsp_yet", rsp_valid[0], 1'b0);
    #1 rstn = 1'b0;
    #1;
    chk("abort_rd_low", rd[0], 1'b0);
    chk("abort_wr_low", wr[0], 1'b0);
    chk("abort_rsp_valid_low", rsp_valid[0], 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_cmd_ready", cmd_ready[0], 1'b1);
    chk("abort_no_rsp", lane[0].n_rsp - r0, 0);
    chk("abort_no_more_strobes", lane[0].n_rd + lane[0].n_wr - s0, 1);

    // Lane 1: three-cycle read latency.
    send(1, 1'b1, 32'h8, 32'h12345678);
    send(1, 1'b0, 32'h0, 32'h0);
    send(1, 1'b0, 32'h8, 32'h0);
    wait_idle(1);
    chk("lat3_rd_data", lane[1].last_rdata, 32'h12345678);
    chk("lat3_rsp_count", lane[1].n_rsp, 3);
    chk("lat3_rd_strobes", lane[1].n_rd, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Bus initiator for the simple CPU peripheral bus: wr/waddr/wdata write strobe; rd/raddr read strobe; registered rdata.
- Accepts read/write commands on a valid/ready channel and buffers them in a small FIFO.
- Issues each command as a single-cycle strobe to the peripheral.
- Returns one in-order response per command on a valid/ready channel. Sits between a command source (debug UART, test sequencer) and memory-mapped peripherals such as the segment-LED register block.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LATENCY, 1, cycles from the rd strobe cycle until rdata is valid; must be >= 1.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept (= not full).
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  target address.
- cmd_wdata  in  DW  write data (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_we  out  1  echo of the command type.
- rsp_rdata  out  DW  read data; 0 for writes.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- wr  out  1  write strobe, one cycle per write.
- waddr  out  AW  write address.
- wdata  out  DW  write data.
- rd  out  1  read strobe, one cycle per read.
- raddr  out  AW  read address.
- rdata  in  DW  peripheral read data.

Behaviour:
- Reset (async, rstn low):
  - FSM to IDLE; FIFO emptied.
  - wr, rd, rsp_valid, rsp_we = 0; waddr, wdata, raddr, rsp_rdata = 0.
  - Cleared immediately, including mid-transaction; in-flight command and queued commands are discarded with no response.
  - After release, cmd_ready = 1.
- FIFO:
  - Push on cmd_valid & cmd_ready.
  - cmd_ready = ~full; a same-cycle pop does not make room for a push.
  - A push into the empty FIFO is visible to the FSM in the next cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO non-empty, pop head, latch command, go ISSUE.
  - ISSUE (exactly 1 cycle), write: wr=1, waddr/wdata = command; next state RESP with rsp_we=1, rsp_rdata=0.
  - ISSUE (exactly 1 cycle), read: rd=1, raddr = command; load counter = RD_LATENCY; next state WAIT.
  - WAIT: decrement counter each cycle. In the cycle the counter is 1, sample rdata into rsp_rdata at the clock edge, set rsp_we=0, go RESP.
  - RESP: rsp_valid=1; rsp_we and rsp_rdata held stable until rsp_ready; on rsp_valid & rsp_ready go IDLE.
- Strobe and response timing:
  - Read: rsp_valid rises RD_LATENCY+1 cycles after the rd cycle.
  - Write: rsp_valid rises 1 cycle after the wr cycle.
  - wr and rd are never both 1; each is high for exactly one cycle per command.
  - waddr, wdata and raddr hold their last value between strobes.
- Ordering and back-pressure:
  - Strictly one outstanding transaction; responses in command order.
  - Minimum 3 cycles per write and RD_LATENCY+3 per read, with rsp_ready=1.
  - With rsp_ready low the FSM stalls in RESP; the FIFO keeps accepting until full. Capacity is FIFO_DEPTH + 1 commands (including the one held in the FSM).
- Addresses and data pass through unchecked; widths are fixed, no arithmetic on data.

Test Plan:
- Slave model for all scenarios: version register 0x01 at address 0, data register at address 4, RD_LATENCY=1.
- Write 0x000000A5 to addr 4, rsp_ready=1 -> exactly one wr cycle with waddr=4, wdata=0xA5; rsp_valid one cycle later with rsp_we=1, rsp_rdata=0; busy drops after the handshake.
- Read addr 0 -> one rd cycle with raddr=0; rsp_valid 2 cycles later with rsp_we=0, rsp_rdata=0x00000001.
- Write 4 <- 0x5A5A5A5A, then read 4, issued back-to-back -> responses in order: write ack, then rsp_rdata=0x5A5A5A5A; no overlap between wr and rd.
- rsp_ready=0; offer 6 commands back-to-back -> exactly 5 accepted, then cmd_ready=0; only the first strobe issued. Raise rsp_ready -> 5 responses in order; cmd_ready returns to 1 after the first pop.
- Assert rstn low during WAIT of a read -> rd, wr, rsp_valid = 0 immediately. After release: busy=0, cmd_ready=1, no response ever emitted for the aborted or queued commands.
- RD_LATENCY=3 with a 3-stage slave -> rsp_valid 4 cycles after rd, correct data; no early capture.
